// File: rtl/alu_pkg.sv
// Shared ALU package: common widths, multiply-sequencer state encoding and latency.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 64;

  // The sequencer retires one multiplier bit per cycle and never exits early,
  // so the latency equals the operand width.
  localparam int MULT_LATENCY = ALU_DATA_WIDTH;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_RUN,
    MS_DONE
  } mult_state_t;

endpackage

// File: rtl/alu_zero.sv
// Zero detect on an ALU datapath word.
module alu_zero #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] a,
  output logic                  zero
);

  assign zero = (a == '0);

endmodule

// File: rtl/alu_mult_seq.sv
// Shift-and-add multiply sequencer: low DATA_WIDTH bits of A*B, one multiplier
// bit per cycle, ready/valid on both sides, synchronous abort.
//
// state   | meaning
// --------+--------------------------------------------------------------
// MS_IDLE | waiting for operands; in_ready high
// MS_RUN  | DATA_WIDTH add/shift iterations, cnt counts completed steps
// MS_DONE | product held on result with out_valid until out_ready/abort
module alu_mult_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  is_zero
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  mult_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Next-state, datapath step and handshake outputs.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    in_ready  = (state_q == MS_IDLE);
    out_valid = (state_q == MS_DONE);

    unique case (state_q)
      MS_IDLE: begin
        // A squash in the same cycle as the offer means the offer is stale.
        if (in_valid && !abort) begin
          mcand_d  = A;
          mplier_d = B;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MS_RUN;
        end
      end
      MS_RUN: begin
        if (abort) begin
          acc_d   = '0;
          state_d = MS_IDLE;
        end else begin
          // Carry-out is dropped: only the low word of the product is kept.
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = MS_DONE;
          end
        end
      end
      MS_DONE: begin
        // Abort wins over the consumer handshake.
        if (abort) begin
          acc_d   = '0;
          state_d = MS_IDLE;
        end else if (out_ready) begin
          state_d = MS_IDLE;
        end
      end
      default: begin
        state_d = MS_IDLE;
      end
    endcase
  end

  // FSM and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MS_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result = acc_q;

  alu_zero #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_zero (
    .a   (acc_q),
    .zero(is_zero)
  );

endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq: transaction-level model plus directed literal vectors.
module tb_alu_mult_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a_i = '0;
  logic [63:0] b_i = '0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        is_zero;

  int n_checks = 0;
  int n_pass   = 0;

  alu_mult_seq #(.DATA_WIDTH(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a_i),
    .B        (b_i),
    .abort    (abort),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .is_zero  (is_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  // Transaction model: an accepted pair becomes a pending product that appears
  // MULT_LATENCY edges later and is held until consumed or squashed.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  logic [63:0] m_prod = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
    end else if (m_done) begin
      if (abort || out_ready) m_done = 1'b0;
    end else if (m_busy) begin
      if (abort) m_busy = 1'b0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (in_valid && !abort) begin
      m_busy = 1'b1;
      m_left = MULT_LATENCY;
      m_prod = a_i * b_i;
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("model_in_ready", 64'(in_ready), 64'(!m_busy && !m_done));
      chk("model_out_valid", 64'(out_valid), 64'(m_done));
      if (m_done) begin
        chk("model_result", result, m_prod);
        chk("model_is_zero", 64'(is_zero), 64'(m_prod == 64'd0));
      end
    end
  end

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input logic exp_zero,
                        input string nm, input int hold);
    int cyc;
    bit seen;
    @(negedge clk);
    a_i = a;
    b_i = b;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_i = {$urandom, $urandom};
    b_i = {$urandom, $urandom};
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      seen = out_valid;
    end
    chk({nm, "_latency"}, 64'(cyc), 64'(MULT_LATENCY));
    chk({nm, "_result"}, result, exp_res);
    chk({nm, "_is_zero"}, 64'(is_zero), 64'(exp_zero));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        in_valid = 1'b1;
        a_i = 64'd11;
        b_i = 64'd13;
        chk({nm, "_hold_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_hold_result"}, result, exp_res);
        chk({nm, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({nm, "_ready_after"}, 64'(in_ready), 64'd1);
    chk({nm, "_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    bit seen;
    logic [63:0] ra, rb;

    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_is_zero", 64'(is_zero), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(64'd3, 64'd5, 64'd15, 1'b0, "mul_3x5", 0);
    run_op(64'd0, 64'hDEAD_BEEF, 64'd0, 1'b1, "mul_0xdb", 0);
    run_op(64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1, "mul_wrap", 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "mul_m1m1", 0);
    run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0, "mul_m7x6", 0);
    run_op(64'h1234, 64'h10, 64'h12340, 1'b0, "mul_bp", 10);

    // Squash at RUN cycle 20.
    @(negedge clk);
    a_i = 64'd3;
    b_i = 64'd5;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    abort = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_pulse", 64'(seen), 64'd0);
    run_op(64'd7, 64'd9, 64'd63, 1'b0, "mul_7x9", 0);

    // Asynchronous reset between edges while running.
    @(negedge clk);
    a_i = 64'd123;
    b_i = 64'd456;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_is_zero", 64'(is_zero), 64'd1);
    #1 reset = 1'b0;
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mrst_no_pulse", 64'(seen), 64'd0);

    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 50 == 0) rb = '0;
      if (i % 7 == 0) ra = ra >> $urandom_range(63, 0);
      run_op(ra, rb, ra * rb, (ra * rb) == 64'd0, "rand", 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
